ps2_device_tx_apb: RTL and testbench

APB-controlled PS/2 device-side transmitter: it drives `ps2_clk` and `ps2_data` the way a keyboard does, sending bytes queued by software. In the simulator it pairs with the PS/2 receiver, so both ends of the link are closed inside the SoC and scan-code traffic can be scripted without an external keyboard model. Bytes are written over APB into an internal FIFO. An FSM serialises each byte as an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.

---
 rtl/ps2_device_tx_apb.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_device_tx_apb.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx_apb.sv
// APB-fed PS/2 device-side transmitter: byte FIFO plus an 11-bit frame serialiser (keyboard timing).
// Optional feature macro PS2_TX_ERRINJ_EN: STATUS bit4 arms a one-shot even-parity frame.
//
// state | meaning
// IDLE  | lines high, pop next byte when FIFO non-empty
// HIGH  | ps2_clk high, current bit driven, CLK_DIV cycles
// LOW   | ps2_clk low, bit held for receiver, CLK_DIV cycles
// GAP   | both lines high for FRAME_GAP cycles after stop bit
module ps2_device_tx_apb #(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FRAME_GAP  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_paddr,
  input  logic        in_psel,
  input  logic        in_penable,
  input  logic [2:0]  in_pprot,
  input  logic        in_pwrite,
  input  logic [31:0] in_pwdata,
  input  logic [3:0]  in_pstrb,
  output logic        in_pready,
  output logic [31:0] in_prdata,
  output logic        in_pslverr,
  output logic        ps2_clk,
  output logic        ps2_data
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int TMAX = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int TW   = $clog2(TMAX);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW, ST_GAP} state_t;

  state_t          state_q;
  logic [TW-1:0]   tmr_q;
  logic [3:0]      bit_idx_q;
  logic [10:0]     shift_q;
  logic            ps2_clk_q;
  logic            ps2_data_q;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            ovf_q;
  logic [31:0]     prdata_q;
  logic [31:0]     prdata_d;
  logic            pslverr_q;

  logic            access;
  logic            bad_addr;
  logic            wr_data;
  logic            wr_stat;
  logic            rd_stat;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;
  logic            inj_flag;
  logic [7:0]      head;
  logic [31:0]     status;
  logic            unused_bits;

  assign access     = in_psel & in_penable;
  assign bad_addr   = access & in_paddr[3];
  assign wr_data    = access & in_pwrite & (in_paddr[3:2] == 2'd0) & in_pstrb[0];
  assign wr_stat    = access & in_pwrite & (in_paddr[3:2] == 2'd1);
  assign rd_stat    = access & ~in_pwrite & (in_paddr[3:2] == 2'd1);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  // Fullness uses the pre-edge count, so a push racing a pop on a full FIFO is dropped.
  assign push       = wr_data & ~fifo_full;
  assign pop        = (state_q == ST_IDLE) & ~fifo_empty;
  assign count_d    = count_q + CW'(push) - CW'(pop);
  assign head       = mem_q[rd_ptr_q];

  assign unused_bits = ^{in_pprot, in_paddr[31:4], in_paddr[1:0], in_pwdata[31:8], in_pstrb[3:1]};

`ifdef PS2_TX_ERRINJ_EN
  logic inj_q;
  always_ff @(posedge clock) begin
    if (!reset) begin
      inj_q <= 1'b0;
    end else if (wr_stat & in_pwdata[4]) begin
      inj_q <= 1'b1;
    end else if (pop) begin
      inj_q <= 1'b0;
    end
  end
  assign inj_flag = inj_q;
`else
  assign inj_flag = 1'b0;
`endif

  always_comb begin
    status        = '0;
    status[0]     = (state_q != ST_IDLE) | ~fifo_empty;
    status[1]     = fifo_full;
    status[2]     = fifo_empty;
    status[3]     = ovf_q;
    status[4]     = inj_flag;
    status[11:8]  = 4'(count_q);
    prdata_d      = rd_stat ? status : '0;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_pwdata[7:0];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      if (wr_data & fifo_full) begin
        ovf_q <= 1'b1;
      end else if (wr_stat & in_pwdata[3]) begin
        ovf_q <= 1'b0;
      end
      prdata_q  <= prdata_d;
      pslverr_q <= bad_addr;
    end
  end

  // Line registers follow the state with one cycle of lag; data moves only as ps2_clk rises.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '1;
      ps2_clk_q  <= 1'b1;
      ps2_data_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ps2_clk_q  <= 1'b1;
          ps2_data_q <= 1'b1;
          if (pop) begin
            shift_q   <= {1'b1, (~^head) ^ inj_flag, head, 1'b0};
            bit_idx_q <= '0;
            tmr_q     <= TW'(CLK_DIV - 1);
            state_q   <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          ps2_clk_q  <= 1'b1;
          ps2_data_q <= shift_q[0];
          if (tmr_q == '0) begin
            tmr_q   <= TW'(CLK_DIV - 1);
            state_q <= ST_LOW;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        ST_LOW: begin
          ps2_clk_q  <= 1'b0;
          ps2_data_q <= shift_q[0];
          if (tmr_q == '0) begin
            if (bit_idx_q == 4'd10) begin
              tmr_q   <= TW'(FRAME_GAP - 1);
              state_q <= ST_GAP;
            end else begin
              bit_idx_q <= bit_idx_q + 4'd1;
              shift_q   <= {1'b1, shift_q[10:1]};
              tmr_q     <= TW'(CLK_DIV - 1);
              state_q   <= ST_HIGH;
            end
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        ST_GAP: begin
          ps2_clk_q  <= 1'b1;
          ps2_data_q <= 1'b1;
          if (tmr_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            tmr_q <= tmr_q - TW'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_pready  = 1'b1;
  assign in_prdata  = prdata_q;
  assign in_pslverr = pslverr_q;
  assign ps2_clk    = ps2_clk_q;
  assign ps2_data   = ps2_data_q;

endmodule

// File: tb/tb_ps2_device_tx_apb.sv
// Bench for ps2_device_tx_apb: register table, frame timing, loopback receiver model, random bursts.
module tb_ps2_device_tx_apb;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int FRAME_GAP  = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] in_paddr = '0;
  logic        in_psel = 1'b0;
  logic        in_penable = 1'b0;
  logic [2:0]  in_pprot = '0;
  logic        in_pwrite = 1'b0;
  logic [31:0] in_pwdata = '0;
  logic [3:0]  in_pstrb = '0;
  logic        in_pready;
  logic [31:0] in_prdata;
  logic        in_pslverr;
  logic        ps2_clk;
  logic        ps2_data;

  ps2_device_tx_apb #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH), .FRAME_GAP(FRAME_GAP)) dut (
    .clock(clock), .reset(reset), .in_paddr(in_paddr), .in_psel(in_psel),
    .in_penable(in_penable), .in_pprot(in_pprot), .in_pwrite(in_pwrite),
    .in_pwdata(in_pwdata), .in_pstrb(in_pstrb), .in_pready(in_pready),
    .in_prdata(in_prdata), .in_pslverr(in_pslverr), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Receiver model: samples ps2_data on each ps2_clk falling edge, decodes 11-bit frames.
  logic        prev_clk = 1'b1;
  logic        prev_data = 1'b1;
  int          nbits = 0;
  logic [10:0] fbits = '0;
  logic [10:0] fr_q[$];
  logic [7:0]  rx_q[$];
  int          rx_bad = 0;
  int          falls = 0;
  int          frames = 0;
  int          start_cyc = 0;
  int          frame_len = -1;
  bit          len_pending = 1'b0;

  always @(negedge clock) begin
    if (!reset) begin
      nbits = 0;
      len_pending = 1'b0;
    end else begin
      if (prev_clk && ps2_clk && prev_data && !ps2_data && nbits == 0) start_cyc = cyc;
      if (prev_clk && !ps2_clk) begin
        falls++;
        fbits[nbits] = ps2_data;
        nbits++;
        if (nbits == 11) begin
          nbits = 0;
          len_pending = 1'b1;
          fr_q.push_back(fbits);
          if (fbits[0] == 1'b0 && fbits[10] == 1'b1 && $countones(fbits[9:1]) % 2 == 1)
            rx_q.push_back(fbits[8:1]);
          else
            rx_bad++;
        end
      end
      if (!prev_clk && ps2_clk && len_pending) begin
        frame_len = cyc - start_cyc;
        len_pending = 1'b0;
        frames++;
      end
    end
    prev_clk = ps2_clk;
    prev_data = ps2_data;
  end

  logic [7:0] exp_q[$];
  int         rx_rd = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output logic err);
    @(negedge clock);
    in_psel = 1'b1; in_penable = 1'b0; in_pwrite = wr;
    in_paddr = addr; in_pwdata = wdata; in_pstrb = strb;
    @(negedge clock);
    in_penable = 1'b1;
    @(negedge clock);
    rdata = in_prdata; err = in_pslverr;
    in_psel = 1'b0; in_penable = 1'b0; in_pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] r; logic e;
    apb_xfer(1'b1, addr, data, 4'h1, r, e);
  endtask

  task automatic rd_check(input logic [31:0] addr, input logic [31:0] exp, input string name);
    logic [31:0] r; logic e;
    apb_xfer(1'b0, addr, 32'h0, 4'h0, r, e);
    check(name, r, exp);
  endtask

  function automatic logic [31:0] exp_status(input bit busy, input int cnt, input bit ovf, input bit inj);
    return (32'(cnt) << 8) | (32'(inj) << 4) | (32'(ovf) << 3) |
           (32'(cnt == 0) << 2) | (32'(cnt == FIFO_DEPTH) << 1) | 32'(busy);
  endfunction

  task automatic wait_idle(input string name);
    logic [31:0] st; logic e; bit done;
    done = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      apb_xfer(1'b0, 32'h4, 32'h0, 4'h0, st, e);
      if (!st[0]) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: busy still 1 after timeout, expected 0", name);
    end
  endtask

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (frames < target && n < 5000) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(frames >= target), 32'd1);
  endtask

  task automatic check_rx(input string name);
    logic [7:0] e;
    check({name, "_count"}, 32'(rx_q.size() - rx_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(name, (rx_rd < rx_q.size()) ? 32'(rx_q[rx_rd]) : 32'hDEAD, 32'(e));
      rx_rd++;
    end
    rx_rd = rx_q.size();
  endtask

  // Writes n random bytes while idle: first byte pops at once, FIFO_DEPTH queue, rest dropped.
  task automatic run_round(input int n, input string name);
    logic [7:0] b; int accepted;
    accepted = (n < 1 + FIFO_DEPTH) ? n : 1 + FIFO_DEPTH;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      if (i < accepted) exp_q.push_back(b);
      wr(32'h0, {24'h0, b});
    end
    rd_check(32'h4, exp_status(1'b1, accepted - 1, n > accepted, 1'b0), {name, "_status"});
    wr(32'h4, 32'h8);
    rd_check(32'h4, exp_status(1'b1, accepted - 1, 1'b0, 1'b0), {name, "_ovf_clr"});
    wait_idle({name, "_drain"});
    check_rx({name, "_rx"});
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    logic        e;
    int          exp_bits[11] = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1};
    int          f0;
    int          fall0;
    int          rxs0;
    int          bad0;
    int          n;

    vecs.push_back('{1'b0, 32'h4,  32'h0,  4'h0, 32'h4, 1'b0, "status_reset"});
    vecs.push_back('{1'b0, 32'h0,  32'h0,  4'h0, 32'h0, 1'b0, "data_read"});
    vecs.push_back('{1'b0, 32'h8,  32'h0,  4'h0, 32'h0, 1'b1, "bad8_read"});
    vecs.push_back('{1'b1, 32'h8,  32'hAB, 4'h1, 32'h0, 1'b1, "bad8_write"});
    vecs.push_back('{1'b0, 32'h4,  32'h0,  4'h0, 32'h4, 1'b0, "status_after_bad8"});
    vecs.push_back('{1'b1, 32'hC,  32'h5A, 4'h1, 32'h0, 1'b1, "badc_write"});
    vecs.push_back('{1'b0, 32'hC,  32'h0,  4'h0, 32'h0, 1'b1, "badc_read"});
    vecs.push_back('{1'b1, 32'h0,  32'h55, 4'h0, 32'h0, 1'b0, "data_nostrobe"});
    vecs.push_back('{1'b0, 32'h4,  32'h0,  4'h0, 32'h4, 1'b0, "status_nostrobe"});
    vecs.push_back('{1'b1, 32'h4,  32'h8,  4'h1, 32'h0, 1'b0, "status_write"});
    vecs.push_back('{1'b0, 32'h14, 32'h0,  4'h0, 32'h4, 1'b0, "status_alias"});

    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
    check("rst_ps2_data", 32'(ps2_data), 32'd1);
    check("rst_prdata", in_prdata, 32'h0);
    check("rst_pslverr", 32'(in_pslverr), 32'd0);
    check("pready", 32'(in_pready), 32'd1);
    reset = 1'b1;

    foreach (vecs[i]) begin
      apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, r, e);
      check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
      if (!vecs[i].wr) check(vecs[i].name, r, vecs[i].exp_rdata);
    end
    check("table_no_frames", 32'(falls), 32'd0);

    // 0x1C: write latency, bit pattern, frame length, busy through frame and gap.
    exp_q.push_back(8'h1C);
    f0 = frames;
    wr(32'h0, 32'h1C);
    check("lat_e0_data", 32'(ps2_data), 32'd1);
    @(negedge clock);
    check("lat_e1_data", 32'(ps2_data), 32'd1);
    @(negedge clock);
    check("lat_e2_start", 32'(ps2_data), 32'd0);
    check("lat_e2_clk", 32'(ps2_clk), 32'd1);
    rd_check(32'h4, 32'h5, "busy_in_frame");
    wait_frames(f0 + 1, "frame_1c_done");
    rd_check(32'h4, 32'h5, "busy_in_gap");
    check("frame_len", 32'(frame_len), 32'(22 * CLK_DIV));
    for (int i = 0; i < 11; i++)
      check($sformatf("bit%0d_1c", i), (fr_q.size() > 0) ? 32'(fr_q[fr_q.size() - 1][i]) : 32'hDEAD,
            32'(exp_bits[i]));
    wait_idle("idle_after_1c");
    rd_check(32'h4, 32'h4, "status_idle");
    check_rx("rx_1c");

    // 0x00 and 0xFF: both frames carry parity 1.
    f0 = fr_q.size();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    wr(32'h0, 32'h00);
    wr(32'h0, 32'hFF);
    wait_idle("idle_after_00ff");
    check("par_00", (fr_q.size() > f0) ? 32'(fr_q[f0][9]) : 32'hDEAD, 32'd1);
    check("par_ff", (fr_q.size() > f0 + 1) ? 32'(fr_q[f0 + 1][9]) : 32'hDEAD, 32'd1);
    check_rx("rx_00ff");
    check("rx_bad", 32'(rx_bad), 32'd0);

    // Overflow with ten writes, then randomized bursts.
    run_round(10, "ovf10");
    for (int k = 0; k < 4; k++) begin
      n = $urandom_range(1, 12);
      run_round(n, $sformatf("rnd%0d", k));
    end
    rd_check(32'h4, 32'h4, "status_after_rnd");

    // Reset during bit 5 of a frame with more bytes queued.
    wr(32'h0, 32'h1C);
    wr(32'h0, 32'h55);
    wr(32'h0, 32'h66);
    n = 0;
    while (nbits != 5 && n < 2000) begin
      @(negedge clock);
      n++;
    end
    check("reached_bit5", 32'(nbits), 32'd5);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_clk", 32'(ps2_clk), 32'd1);
    check("midrst_data", 32'(ps2_data), 32'd1);
    reset = 1'b1;
    rd_check(32'h4, 32'h4, "midrst_status");
    fall0 = falls;
    rxs0 = rx_q.size();
    repeat (300) @(negedge clock);
    check("midrst_no_edges", 32'(falls), 32'(fall0));
    check("midrst_no_rx", 32'(rx_q.size()), 32'(rxs0));
    rx_rd = rx_q.size();

`ifdef PS2_TX_ERRINJ_EN
    bad0 = rx_bad;
    f0 = fr_q.size();
    wr(32'h4, 32'h10);
    rd_check(32'h4, 32'h14, "inj_flag_set");
    exp_q.push_back(8'h1C);
    wr(32'h0, 32'h1C);
    wr(32'h0, 32'h1C);
    wait_idle("idle_after_inj");
    check("inj_par_bad", (fr_q.size() > f0) ? 32'(fr_q[f0][9]) : 32'hDEAD, 32'd1);
    check("inj_par_good", (fr_q.size() > f0 + 1) ? 32'(fr_q[f0 + 1][9]) : 32'hDEAD, 32'd0);
    check("inj_discarded", 32'(rx_bad), 32'(bad0 + 1));
    rd_check(32'h4, 32'h4, "inj_flag_clear");
    check_rx("rx_inj");
`else
    bad0 = rx_bad;
    f0 = fr_q.size();
    wr(32'h4, 32'h10);
    rd_check(32'h4, 32'h4, "noinj_bit4");
    exp_q.push_back(8'h1C);
    wr(32'h0, 32'h1C);
    wait_idle("idle_after_noinj");
    check("noinj_par", (fr_q.size() > f0) ? 32'(fr_q[f0][9]) : 32'hDEAD, 32'd0);
    check("noinj_bad", 32'(rx_bad), 32'(bad0));
    check_rx("rx_noinj");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
